// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares a single ALU between two requesters (0: calculator_core,
//   1: memory/recall or constant unit) using round-robin arbitration.
//   One transaction is in flight at a time: grant and latch operands in
//   IDLE, present them to the ALU in ISSUE, collect the result in WAIT,
//   and hand it back to the owning requester in RETURN.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req_a / i_req_b     packed operands, requester n at [n*DATA_WIDTH +: DATA_WIDTH]
//   i_req_op              2-bit op per requester at [2n +: 2]
//   i_req_signed          signed-mode flag per requester
//   i_req_valid           request valid per requester
//   o_req_ready           request accepted, one-hot or zero
//   o_rsp_result/_error   latched ALU result/error, shared by both requesters
//   o_rsp_valid           result valid, one-hot to the owner
//   i_rsp_ready           per-requester result ready
//   o_alu_input_*         operand handshake toward the ALU
//   i_alu_result/_error/_result_valid, o_alu_result_ready
//                         result handshake from the ALU
//   o_busy                high whenever not IDLE
//   o_owner               index of the current or last granted requester
module alu_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*DATA_WIDTH-1:0] i_req_a,
  input  logic [2*DATA_WIDTH-1:0] i_req_b,
  input  logic [3:0]              i_req_op,
  input  logic [1:0]              i_req_signed,
  input  logic [1:0]              i_req_valid,
  output logic [1:0]              o_req_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_result,
  output logic                    o_rsp_error,
  output logic [1:0]              o_rsp_valid,
  input  logic [1:0]              i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_alu_input_a,
  output logic [DATA_WIDTH-1:0]   o_alu_input_b,
  output logic [1:0]              o_alu_input_op,
  output logic                    o_alu_input_signed,
  output logic                    o_alu_input_valid,
  input  logic                    i_alu_input_ready,
  input  logic [DATA_WIDTH-1:0]   i_alu_result,
  input  logic                    i_alu_error,
  input  logic                    i_alu_result_valid,
  output logic                    o_alu_result_ready,
  output logic                    o_busy,
  output logic                    o_owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

  state_t                  state, state_nxt;
  logic                    last_grant;
  logic [DATA_WIDTH-1:0]   a_q, b_q, res_q;
  logic [1:0]              op_q;
  logic                    sgn_q, err_q;

  logic                    grant_any, grant_idx;
  logic                    req_fire, alu_in_fire, alu_res_fire, rsp_fire;

  // Round-robin: a lone requester always wins; on contention the one that
  // was not served last wins. last_grant resets to 1 so requester 0 wins first.
  assign grant_any = |i_req_valid;
  assign grant_idx = (&i_req_valid) ? ~last_grant : i_req_valid[1];

  assign req_fire     = (state == IDLE) && grant_any;
  assign alu_in_fire  = (state == ISSUE) && i_alu_input_ready;
  assign alu_res_fire = (state == WAIT) && i_alu_result_valid;
  assign rsp_fire     = (state == RETURN) && i_rsp_ready[o_owner];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire)     state_nxt = ISSUE;
      ISSUE:   if (alu_in_fire)  state_nxt = WAIT;
      WAIT:    if (alu_res_fire) state_nxt = RETURN;
      RETURN:  if (rsp_fire)     state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend only on state, owner and i_req_valid, so there
  // is no combinational path from the response or ALU inputs to o_req_ready.
  always_comb begin
    o_req_ready        = 2'b00;
    o_rsp_valid        = 2'b00;
    o_alu_input_valid  = 1'b0;
    o_alu_result_ready = 1'b0;
    if (req_fire)
      o_req_ready = grant_idx ? 2'b10 : 2'b01;
    if (state == RETURN)
      o_rsp_valid = o_owner ? 2'b10 : 2'b01;
    if (state == ISSUE)
      o_alu_input_valid = 1'b1;
    if (state == WAIT)
      o_alu_result_ready = 1'b1;
  end

  assign o_busy             = (state != IDLE);
  assign o_alu_input_a      = a_q;
  assign o_alu_input_b      = b_q;
  assign o_alu_input_op     = op_q;
  assign o_alu_input_signed = sgn_q;
  assign o_rsp_result       = res_q;
  assign o_rsp_error        = err_q;

  // ---- control: state, owner, round-robin history ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      o_owner    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (req_fire) o_owner    <= grant_idx;
      if (rsp_fire) last_grant <= o_owner;
    end
  end

  // ---- operand latch: captured on the request handshake ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 2'b00;
      sgn_q <= 1'b0;
    end else if (req_fire) begin
      a_q   <= grant_idx ? i_req_a[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_a[DATA_WIDTH-1:0];
      b_q   <= grant_idx ? i_req_b[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_b[DATA_WIDTH-1:0];
      op_q  <= grant_idx ? i_req_op[3:2] : i_req_op[1:0];
      sgn_q <= i_req_signed[grant_idx];
    end
  end

  // ---- result latch: held after RETURN until the next capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else if (alu_res_fire) begin
      res_q <= i_alu_result;
      err_q <= i_alu_error;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2*DW-1:0] i_req_a, i_req_b;
  logic [3:0]      i_req_op;
  logic [1:0]      i_req_signed, i_req_valid, o_req_ready;
  logic [DW-1:0]   o_rsp_result;
  logic            o_rsp_error;
  logic [1:0]      o_rsp_valid, i_rsp_ready;
  logic [DW-1:0]   o_alu_input_a, o_alu_input_b;
  logic [1:0]      o_alu_input_op;
  logic            o_alu_input_signed, o_alu_input_valid, i_alu_input_ready;
  logic [DW-1:0]   i_alu_result;
  logic            i_alu_error, i_alu_result_valid, o_alu_result_ready;
  logic            o_busy, o_owner;

  // Per-requester stimulus, packed onto the DUT buses.
  logic [DW-1:0] ra [2];
  logic [DW-1:0] rb [2];
  logic [1:0]    rop[2];
  logic          rsg[2];
  assign i_req_a      = {ra[1], ra[0]};
  assign i_req_b      = {rb[1], rb[0]};
  assign i_req_op     = {rop[1], rop[0]};
  assign i_req_signed = {rsg[1], rsg[0]};

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_op(i_req_op),
    .i_req_signed(i_req_signed), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .o_rsp_result(o_rsp_result), .o_rsp_error(o_rsp_error), .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_alu_input_a(o_alu_input_a), .o_alu_input_b(o_alu_input_b),
    .o_alu_input_op(o_alu_input_op), .o_alu_input_signed(o_alu_input_signed),
    .o_alu_input_valid(o_alu_input_valid), .i_alu_input_ready(i_alu_input_ready),
    .i_alu_result(i_alu_result), .i_alu_error(i_alu_error),
    .i_alu_result_valid(i_alu_result_valid), .o_alu_result_ready(o_alu_result_ready),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: who was served last, and the last result handed back.
  int            model_last;
  logic [DW-1:0] model_res;
  logic          model_err;
  int            grant_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU used as the bench-side ALU: 00 add, 01 sub, 10 mul, 11 div.
  task automatic alu_ref(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] r, output logic e);
    e = 1'b0;
    case (op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: r = a * b;
      default: begin
        if (b == 0) begin r = '0; e = 1'b1; end
        else r = a / b;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, o_req_ready, 0);
    chk({tag, "_rsp_valid"}, o_rsp_valid, 0);
    chk({tag, "_rsp_result"}, o_rsp_result, 0);
    chk({tag, "_rsp_error"}, o_rsp_error, 0);
    chk({tag, "_alu_in_valid"}, o_alu_input_valid, 0);
    chk({tag, "_alu_a"}, o_alu_input_a, 0);
    chk({tag, "_alu_b"}, o_alu_input_b, 0);
    chk({tag, "_alu_op"}, o_alu_input_op, 0);
    chk({tag, "_alu_signed"}, o_alu_input_signed, 0);
    chk({tag, "_alu_res_ready"}, o_alu_result_ready, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_owner"}, o_owner, 0);
  endtask

  // Called one time unit after a rising edge with the DUT in IDLE.
  task automatic do_reset();
    i_req_valid = 2'b00; i_rsp_ready = 2'b00;
    i_alu_input_ready = 1'b0; i_alu_result_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst");
    model_last = 1;
    model_res = '0;
    model_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // One complete transaction with the given request mask and handshake delays.
  task automatic run_txn(input logic [1:0] mask, input int in_dly, input int res_dly, input int rsp_dly);
    int            g;
    logic [DW-1:0] er;
    logic          ee;
    g = (mask == 2'b11) ? 1 - model_last : (mask[1] ? 1 : 0);
    alu_ref(rop[g], ra[g], rb[g], er, ee);
    grant_log.push_back(g);

    i_req_valid = mask; i_rsp_ready = 2'b00;
    i_alu_input_ready = 1'b0; i_alu_result_valid = 1'b0;
    #1;
    chk("grant_ready", o_req_ready, (g == 1) ? 2'b10 : 2'b01);
    chk("idle_not_busy", o_busy, 0);
    step();

    for (int d = 0; d <= in_dly; d++) begin
      i_alu_input_ready = (d == in_dly);
      #1;
      chk("issue_valid", o_alu_input_valid, 1);
      chk("issue_a", o_alu_input_a, ra[g]);
      chk("issue_b", o_alu_input_b, rb[g]);
      chk("issue_op", o_alu_input_op, rop[g]);
      chk("issue_signed", o_alu_input_signed, rsg[g]);
      chk("issue_res_ready", o_alu_result_ready, 0);
      chk("issue_req_ready", o_req_ready, 0);
      chk("issue_busy", o_busy, 1);
      chk("issue_owner", o_owner, g);
      step();
    end
    i_alu_input_ready = 1'b0;

    for (int d = 0; d <= res_dly; d++) begin
      i_alu_result_valid = (d == res_dly);
      i_alu_result = (d == res_dly) ? er : DW'($urandom);
      i_alu_error  = (d == res_dly) ? ee : 1'($urandom);
      #1;
      chk("wait_res_ready", o_alu_result_ready, 1);
      chk("wait_in_valid", o_alu_input_valid, 0);
      chk("wait_rsp_valid", o_rsp_valid, 0);
      chk("wait_busy", o_busy, 1);
      step();
    end
    i_alu_result_valid = 1'b0;
    i_alu_result = DW'($urandom);
    i_alu_error = 1'($urandom);

    for (int d = 0; d <= rsp_dly; d++) begin
      // Before the real handshake, offer ready on the non-owner only.
      i_rsp_ready = (d == rsp_dly) ? ((g == 1) ? 2'b10 : 2'b01) : ((g == 1) ? 2'b01 : 2'b10);
      #1;
      chk("ret_rsp_valid", o_rsp_valid, (g == 1) ? 2'b10 : 2'b01);
      chk("ret_result", o_rsp_result, er);
      chk("ret_error", o_rsp_error, ee);
      chk("ret_res_ready", o_alu_result_ready, 0);
      chk("ret_busy", o_busy, 1);
      step();
    end
    i_rsp_ready = 2'b00;
    model_last = g;
    model_res = er;
    model_err = ee;
    #1;
    chk("post_rsp_valid", o_rsp_valid, 0);
    chk("post_busy", o_busy, 0);
    chk("post_result_held", o_rsp_result, er);
    chk("post_error_held", o_rsp_error, ee);
    chk("post_owner", o_owner, g);
  endtask

  initial begin
    for (int r = 0; r < 2; r++) begin ra[r] = '0; rb[r] = '0; rop[r] = '0; rsg[r] = 1'b0; end
    i_req_valid = 2'b00; i_rsp_ready = 2'b00; i_alu_input_ready = 1'b0;
    i_alu_result = '0; i_alu_error = 1'b0; i_alu_result_valid = 1'b0;
    rst_n = 1'b0;
    step();
    do_reset();

    // Single requester 0: 7 + 5.
    ra[0] = 16'd7; rb[0] = 16'd5; rop[0] = 2'd0; rsg[0] = 1'b0;
    run_txn(2'b01, 0, 0, 0);
    chk("t1_result", o_rsp_result, 12);

    // Contention from reset: r0 1+1, r1 3*4, alternating grants.
    do_reset();
    grant_log.delete();
    ra[0] = 16'd1; rb[0] = 16'd1; rop[0] = 2'd0; rsg[0] = 1'b0;
    ra[1] = 16'd3; rb[1] = 16'd4; rop[1] = 2'd2; rsg[1] = 1'b1;
    for (int k = 0; k < 4; k++) run_txn(2'b11, 0, 0, 0);
    for (int k = 0; k < 4; k++) chk("rr_order", grant_log[k], k % 2);

    // Divide by zero on r1, then r0 2+2.
    ra[1] = 16'd9; rb[1] = 16'd0; rop[1] = 2'd3;
    run_txn(2'b10, 0, 0, 0);
    ra[0] = 16'd2; rb[0] = 16'd2; rop[0] = 2'd0;
    run_txn(2'b01, 0, 0, 0);

    // Slow ALU and slow consumer.
    ra[0] = 16'h1234; rb[0] = 16'h0011; rop[0] = 2'd1; rsg[0] = 1'b1;
    run_txn(2'b01, 5, 20, 3);

    // Spurious ALU result in IDLE must not be consumed.
    i_req_valid = 2'b00;
    i_alu_result_valid = 1'b1; i_alu_result = 16'hdead; i_alu_error = 1'b1;
    #1;
    chk("spur_res_ready", o_alu_result_ready, 0);
    step();
    i_alu_result_valid = 1'b0;
    #1;
    chk("spur_busy", o_busy, 0);
    chk("spur_rsp_valid", o_rsp_valid, 0);
    chk("spur_result", o_rsp_result, model_res);
    chk("spur_error", o_rsp_error, model_err);

    // Reset in the middle of WAIT, owner r1 with a nonzero previous result.
    ra[1] = 16'd6; rb[1] = 16'd7; rop[1] = 2'd2; rsg[1] = 1'b0;
    i_req_valid = 2'b10;
    step();
    i_req_valid = 2'b00; i_alu_input_ready = 1'b1;
    step();
    i_alu_input_ready = 1'b0;
    #1;
    chk("midrst_in_wait", o_alu_result_ready, 1);
    step();
    do_reset();
    ra[0] = 16'd10; rb[0] = 16'd3; rop[0] = 2'd1;
    run_txn(2'b11, 0, 0, 0);
    chk("midrst_first_r0", model_last, 0);

    // Randomized transactions.
    for (int k = 0; k < 30; k++) begin
      for (int r = 0; r < 2; r++) begin
        ra[r]  = DW'($urandom);
        rb[r]  = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom_range(1, 300));
        rop[r] = 2'($urandom_range(0, 3));
        rsg[r] = 1'($urandom);
      end
      run_txn(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    i_req_valid = 2'b00;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
